// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MIPS HI/LO multiply/divide unit with MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete without effect.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
`ifdef MULDIV_DIV_EN
  localparam state_t DIV_GO = DIV;
`else
  localparam state_t DIV_GO = FIN;
`endif
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_p;
  logic [31:0] r_a, r_hi, r_lo;
  logic        r_neg_p;
  logic        w_last, w_signed;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_sum;
  assign w_last   = r_cnt == 6'd32;
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && dataA[31]) ? -dataA : dataA;
  assign w_mag_b  = (w_signed && dataB[31]) ? -dataB : dataB;
  // r_p holds {acc, multiplier} for MUL and {remainder, dividend->quotient} for DIV
  assign w_sum    = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_a} : 33'd0);
`ifdef MULDIV_DIV_EN
  logic        r_neg_r, r_bz, r_dz;
  logic [33:0] w_diff;
  assign w_diff   = {1'b0, r_p[63:31]} - {2'b0, r_a};
  assign div_zero = r_dz;
`else
  assign div_zero = 1'b0;
`endif
  assign busy = r_state != IDLE;
  assign done = r_state == FIN;
  assign hi   = r_hi;
  assign lo   = r_lo;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = start ? (op[1] ? DIV_GO : MUL) : IDLE;
    else if (r_state == FIN) w_next = IDLE;
    else if (w_last) w_next = FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_p <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
        if (start) begin
          r_cnt   <= '0;
          r_neg_p <= w_signed & (dataA[31] ^ dataB[31]);
          r_p     <= {32'd0, op[1] ? w_mag_a : w_mag_b};
          r_a     <= op[1] ? w_mag_b : w_mag_a;
`ifdef MULDIV_DIV_EN
          r_neg_r <= w_signed & dataA[31];
          r_bz    <= dataB == 32'd0;
`endif
        end
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt + 6'd1;
        if (w_last) {r_hi, r_lo} <= r_neg_p ? -r_p : r_p;
        else r_p <= {w_sum, r_p[31:1]};
      end
`ifdef MULDIV_DIV_EN
      else if (r_state == DIV) begin
        r_cnt <= r_cnt + 6'd1;
        // a zero divisor never borrows, so the remainder ends as |dataA| and restores to dataA
        if (w_last) begin
          r_lo <= r_bz ? 32'hFFFF_FFFF : (r_neg_p ? -r_p[31:0] : r_p[31:0]);
          r_hi <= r_neg_r ? -r_p[63:32] : r_p[63:32];
          r_dz <= r_bz;
        end else r_p <= w_diff[33] ? {r_p[62:0], 1'b0} : {w_diff[31:0], r_p[30:0], 1'b1};
      end
`endif
    end
  end
endmodule
